ram_cmd_arbiter: RTL
====================

Name: ram_cmd_arbiter

Overview:
- Shares the single-port sync RAM command interface (10-bit command, rx_valid in; 8-bit dout, tx_valid out) between two requesters, e.g. the SPI slave front end and a host/BIST port.
- Locks the RAM address pointer to one requester from its address command until its data/read command, so the two requesters' transactions never interleave.
- Routes each read response back to the requester that issued the read.

Parameters:
- LOCK_TIMEOUT, 16: cycles a lock may idle with no accepted owner command before it is forcibly released.
- TIMER_WIDTH, 5: width of the lock idle counter; must hold LOCK_TIMEOUT.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- req0_din  in  10  requester 0 command: [9:8] opcode, [7:0] address/data.
- req0_valid  in  1  requester 0 command valid.
- req0_ready  out  1  requester 0 command accepted this cycle when valid&ready (combinational).
- req0_dout  out  8  requester 0 read data.
- req0_tx_valid  out  1  one-cycle pulse; req0_dout valid.
- req1_din, req1_valid, req1_ready, req1_dout, req1_tx_valid: same as requester 0, for requester 1.
- ram_din  out  10  registered command to the RAM.
- ram_rx_valid  out  1  registered command strobe to the RAM.
- ram_dout  in  8  RAM read data.
- ram_tx_valid  in  1  RAM read-data qualifier.
- lock_to  out  1  registered one-cycle pulse when a lock is released by timeout.

Behaviour:
- Opcodes: 00 = write address, 01 = write data, 10 = read address, 11 = read.
- Reset: ram_din=0, ram_rx_valid=0, reqX_dout=0, reqX_tx_valid=0, lock_to=0. State=IDLE, rr pointer=0 (req0 preferred). Timer=0. Pending reads cleared.
- Reset mid-operation drops in-flight read responses: no tx_valid pulse after reset.
- FSM states:
  - IDLE: grant goes to the valid requester. If both are valid, the rr pointer picks the winner. reqX_ready=1 only for the winner.
  - LOCKED(owner): only owner_ready = owner_valid condition applies, i.e. owner is always ready. The other requester's ready=0.
- Transitions on an accepted command:
  - From IDLE, opcode 00/10 -> LOCKED(X), timer=0.
  - From IDLE, opcode 01/11 -> single-beat transaction, stay IDLE.
  - In LOCKED, owner 01/11 -> IDLE.
  - In LOCKED, owner 00/10 -> stay LOCKED (re-address), timer=0.
- rr pointer: after any accept by X, the pointer points to the other requester.
- Timeout: in LOCKED, the timer increments each cycle with no owner accept. When the timer reaches LOCK_TIMEOUT-1 with no accept that cycle:
  - go to IDLE and pulse lock_to next cycle;
  - point the rr pointer away from the owner.
  - The timer saturates; it never wraps.
- Issue: a command accepted in cycle T appears on ram_din with ram_rx_valid=1 during T+1, for exactly one cycle per accept. Back-to-back accepts produce back-to-back RAM commands.
- Read tracking: each accepted opcode 11 pushes {valid, owner id} through a 2-stage pipe.
  - At the end of T+2, if stage-2 is valid and ram_tx_valid=1, capture ram_dout into that owner's reqX_dout.
  - reqX_tx_valid=1 during T+3 only.
  - Accept-to-response latency is 3 cycles.
  - The other requester's dout is unchanged.
  - Consecutive reads (including from alternating requesters) are fully pipelined, one response per read, in order.
- If stage-2 is valid but ram_tx_valid=0 (fault), no response is sent.
- Simultaneous events: a response delivery, a new accept and a timeout in the same cycle are independent; all take effect.
- An accept in the timeout cycle cancels the timeout.

Test Plan:
- Reset, then req0 sends 00/0x05 and then 01/0xA5 -> ram_din=0x005 then 0x1A5, each with ram_rx_valid high for one cycle. FSM is LOCKED after the first command and IDLE after the second.
- Both requesters valid in IDLE after reset, req0=0x000, req1=0x010 -> req0 wins and req1_ready=0 until req0 sends 01. Then req1 wins the next arbitration.
- req1: 10/0x05, then 11 (RAM holds 0xA5 at address 5) -> req1_dout=0xA5 and req1_tx_valid pulses exactly 3 cycles after the 11 accept. req0_tx_valid stays 0.
- req0 sends 00/0x03 and then goes silent for 16 cycles while req1 is valid -> lock_to pulses, and req1 is accepted the cycle after release.
- Alternating reads req0 11, req1 11, req0 11 on consecutive cycles -> three responses on consecutive cycles, each routed to the correct requester.
- rst asserted one cycle after a read accept -> no tx_valid pulse, all outputs 0, and the FSM is IDLE.

Source files
------------

// File: rtl/ram_cmd_arbiter.sv
// Two-requester arbiter for a single-port sync RAM command interface.
// An address command locks the RAM pointer to its issuer; read data goes back to whoever issued the read.
//
// state | meaning
// IDLE  | no lock; round-robin grant between valid requesters
// LOCK0 | requester 0 owns the address pointer
// LOCK1 | requester 1 owns the address pointer
module ram_cmd_arbiter #(
  parameter int LOCK_TIMEOUT = 16,
  parameter int TIMER_WIDTH  = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] req0_din,
  input  logic       req0_valid,
  output logic       req0_ready,
  output logic [7:0] req0_dout,
  output logic       req0_tx_valid,
  input  logic [9:0] req1_din,
  input  logic       req1_valid,
  output logic       req1_ready,
  output logic [7:0] req1_dout,
  output logic       req1_tx_valid,
  output logic [9:0] ram_din,
  output logic       ram_rx_valid,
  input  logic [7:0] ram_dout,
  input  logic       ram_tx_valid,
  output logic       lock_to
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_WIDTH-1:0] TIMER_MAX  = '1;

  state_t                 state_q, state_d;
  logic                   rr_q, rr_d;
  logic [TIMER_WIDTH-1:0] timer_q, timer_d;
  logic                   lock_to_d;

  logic       acc0, acc1, acc, acc_id;
  logic [9:0] acc_cmd;
  logic       rd_v1_q, rd_id1_q, rd_v2_q, rd_id2_q;

  // The lock owner is ready unconditionally; in IDLE only the arbitration winner is.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      IDLE: begin
        req0_ready = req0_valid & (~req1_valid | ~rr_q);
        req1_ready = req1_valid & (~req0_valid | rr_q);
      end
      LOCK0:   req0_ready = 1'b1;
      LOCK1:   req1_ready = 1'b1;
      default: ;
    endcase
  end

  assign acc0    = req0_valid & req0_ready;
  assign acc1    = req1_valid & req1_ready;
  assign acc     = acc0 | acc1;
  assign acc_id  = acc1;
  assign acc_cmd = acc1 ? req1_din : req0_din;

  // Opcode bit 8 clear means an address command (00/10), which takes or renews the lock.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    timer_d   = timer_q;
    lock_to_d = 1'b0;
    if (acc) rr_d = ~acc_id;
    case (state_q)
      IDLE: begin
        if (acc && !acc_cmd[8]) begin
          state_d = acc_id ? LOCK1 : LOCK0;
          timer_d = '0;
        end
      end
      LOCK0, LOCK1: begin
        if (acc) begin
          if (acc_cmd[8]) state_d = IDLE;
          else            timer_d = '0;
        end else if (timer_q == TIMER_LAST) begin
          state_d   = IDLE;
          lock_to_d = 1'b1;
          rr_d      = (state_q == LOCK0);
        end else if (timer_q != TIMER_MAX) begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      timer_q <= '0;
      lock_to <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      timer_q <= timer_d;
      lock_to <= lock_to_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_din      <= '0;
      ram_rx_valid <= 1'b0;
    end else begin
      ram_rx_valid <= acc;
      if (acc) ram_din <= acc_cmd;
    end
  end

  // Read ownership travels alongside the RAM latency so each response finds its issuer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_v1_q       <= 1'b0;
      rd_id1_q      <= 1'b0;
      rd_v2_q       <= 1'b0;
      rd_id2_q      <= 1'b0;
      req0_dout     <= '0;
      req0_tx_valid <= 1'b0;
      req1_dout     <= '0;
      req1_tx_valid <= 1'b0;
    end else begin
      rd_v1_q       <= acc & (acc_cmd[9:8] == 2'b11);
      rd_id1_q      <= acc_id;
      rd_v2_q       <= rd_v1_q;
      rd_id2_q      <= rd_id1_q;
      req0_tx_valid <= rd_v2_q & ram_tx_valid & ~rd_id2_q;
      req1_tx_valid <= rd_v2_q & ram_tx_valid & rd_id2_q;
      if (rd_v2_q && ram_tx_valid && !rd_id2_q) req0_dout <= ram_dout;
      if (rd_v2_q && ram_tx_valid && rd_id2_q)  req1_dout <= ram_dout;
    end
  end

endmodule
